// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM: states, opcodes, mux selects, trap causes.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADDR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R,
      S_EXEC_I, S_ALUWB, S_JAL, S_BRANCH, S_LUI, S_AUIPC, S_TRAP
   } state_t;

   localparam logic [6:0] OP_LW     = 7'b0000011;
   localparam logic [6:0] OP_SW     = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_B      = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] TRAP_NONE    = 2'b00;
   localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
   localparam logic [1:0] TRAP_TIMEOUT = 2'b10;
   localparam logic [1:0] TRAP_ECALL   = 2'b11;

   // Immediate format straight from the opcode; anything without its own format reads as I-type.
   function automatic logic [2:0] imm_src(input logic [6:0] op);
      case (op)
         OP_SW:             return IMM_S;
         OP_B:              return IMM_B;
         OP_JAL:            return IMM_J;
         OP_LUI, OP_AUIPC:  return IMM_U;
         default:           return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the IR/memory side and the FSM; perf counters appear only with MC_CTRL_PERF_EN.
interface mc_ctrl_fsm_if #(parameter int CNT_W = 32);

   logic [6:0] op;
   logic [2:0] funct3;
   logic       mem_ready;
   logic       mem_req;
   logic       PCUpdate, Branch, AddrSrc, MemWrite, IRWrite, RegWrite;
   logic [1:0] ResultSrc, ALUOp, ALUSrcA, ALUSrcB;
   logic [2:0] ImmSrc;
   logic       halted;
   logic [1:0] trap_cause;
`ifdef MC_CTRL_PERF_EN
   logic [CNT_W-1:0] cycle_cnt, instret_cnt;
`else
   localparam int unused_cnt_w = CNT_W;
`endif

   modport master (
      input  op, funct3, mem_ready,
      output mem_req, PCUpdate, Branch, AddrSrc, MemWrite, IRWrite, RegWrite,
             ResultSrc, ALUOp, ALUSrcA, ALUSrcB, ImmSrc, halted, trap_cause
`ifdef MC_CTRL_PERF_EN
      , output cycle_cnt, instret_cnt
`endif
   );

   modport slave (
      output op, funct3, mem_ready,
      input  mem_req, PCUpdate, Branch, AddrSrc, MemWrite, IRWrite, RegWrite,
             ResultSrc, ALUOp, ALUSrcA, ALUSrcB, ImmSrc, halted, trap_cause
`ifdef MC_CTRL_PERF_EN
      , input cycle_cnt, instret_cnt
`endif
   );

endinterface

// File: rtl/mc_mem_wait_timer.sv
// Counts stalled memory cycles (saturating); expired flags the stall cycle that completes TIMEOUT_CYC waits.
// Combinational expiry so the FSM leaves for TRAP on that same edge; TIMEOUT_CYC=0 never expires.
module mc_mem_wait_timer #(
   parameter int TIMEOUT_W   = 4,
   parameter int TIMEOUT_CYC = 15
) (
   input  logic clk,
   input  logic reset_n,
   input  logic stall,
   input  logic clr,
   output logic expired
);

   localparam logic [TIMEOUT_W:0] LIMIT = (TIMEOUT_W+1)'(TIMEOUT_CYC);

   logic [TIMEOUT_W-1:0] cnt;
   logic [TIMEOUT_W:0]   cnt_inc;

   always_ff @(posedge clk) begin
      if (!reset_n || clr)
         cnt <= '0;
      else if (stall && cnt != '1)
         cnt <= cnt + TIMEOUT_W'(1);
   end

   assign cnt_inc = {1'b0, cnt} + (TIMEOUT_W+1)'(1);
   assign expired = (TIMEOUT_CYC != 0) && stall && (cnt_inc >= LIMIT);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control FSM with variable-latency memory handshake, wait timeout and sticky TRAP.
// Optional perf counters (cycle_cnt, instret_cnt) under MC_CTRL_PERF_EN.
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int TIMEOUT_W       = 4,
   parameter int TIMEOUT_CYC     = 15,
   parameter int TRAP_ON_ILLEGAL = 1,
   parameter int CNT_W           = 32
) (
   input  logic          clk,
   input  logic          reset_n,
   mc_ctrl_fsm_if.master bus
);

   state_t     state, state_nxt;
   logic [1:0] cause_q, cause_nxt;
   logic       mem_state, stall, clr, expired;
   logic       unused_funct3;

   assign mem_state = state inside {S_FETCH, S_MEMREAD, S_MEMWRITE};
   assign stall     = mem_state && !bus.mem_ready;
   assign clr       = bus.mem_ready || (state_nxt != state);
   assign unused_funct3 = ^bus.funct3;

   mc_mem_wait_timer #(.TIMEOUT_W(TIMEOUT_W), .TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .stall   (stall),
      .clr     (clr),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= S_FETCH;
         cause_q <= TRAP_NONE;
      end else begin
         state <= state_nxt;
         if (state_nxt == S_TRAP && state != S_TRAP)
            cause_q <= cause_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cause_nxt = TRAP_NONE;
      case (state)
         S_FETCH, S_MEMREAD, S_MEMWRITE: begin
            if (bus.mem_ready)
               state_nxt = (state == S_FETCH)   ? S_DECODE :
                           (state == S_MEMREAD) ? S_MEMWB  : S_FETCH;
            else if (expired) begin
               state_nxt = S_TRAP;
               cause_nxt = TRAP_TIMEOUT;
            end
         end
         S_DECODE: begin
            case (bus.op)
               OP_LW, OP_SW, OP_JALR: state_nxt = S_MEMADDR;
               OP_R:      state_nxt = S_EXEC_R;
               OP_I:      state_nxt = S_EXEC_I;
               OP_B:      state_nxt = S_BRANCH;
               OP_JAL:    state_nxt = S_JAL;
               OP_LUI:    state_nxt = S_LUI;
               OP_AUIPC:  state_nxt = S_AUIPC;
               OP_SYSTEM: begin
                  state_nxt = S_TRAP;
                  cause_nxt = TRAP_ECALL;
               end
               default: begin
                  // Skipping is safe: PC was already advanced during FETCH.
                  if (TRAP_ON_ILLEGAL != 0) begin
                     state_nxt = S_TRAP;
                     cause_nxt = TRAP_ILLEGAL;
                  end else
                     state_nxt = S_FETCH;
               end
            endcase
         end
         S_MEMADDR: begin
            if (!bus.op[5])     state_nxt = S_MEMREAD;
            else if (bus.op[6]) state_nxt = S_JAL;
            else                state_nxt = S_MEMWRITE;
         end
         S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC, S_JAL: state_nxt = S_ALUWB;
         S_MEMWB, S_ALUWB, S_BRANCH:                state_nxt = S_FETCH;
         S_TRAP:                                    state_nxt = S_TRAP;
         default: begin
            state_nxt = S_TRAP;
            cause_nxt = TRAP_ILLEGAL;
         end
      endcase
   end

   logic       req_c, pcu_c, br_c, adr_c, mw_c, irw_c, rw_c;
   logic [1:0] res_c, aluop_c, srca_c, srcb_c;

   always_comb begin
      req_c = 1'b0; pcu_c = 1'b0; br_c = 1'b0; adr_c = 1'b0;
      mw_c  = 1'b0; irw_c = 1'b0; rw_c = 1'b0;
      res_c = RES_ALUOUT; aluop_c = ALU_ADD; srca_c = SRCA_PC; srcb_c = SRCB_RS2;
      case (state)
         S_FETCH: begin
            req_c  = 1'b1;
            irw_c  = bus.mem_ready;
            pcu_c  = bus.mem_ready;
            res_c  = RES_ALURESULT;
            srcb_c = SRCB_FOUR;
         end
         S_DECODE:   begin srca_c = SRCA_OLDPC; srcb_c = SRCB_IMM; end
         S_MEMADDR:  begin srca_c = SRCA_RS1;   srcb_c = SRCB_IMM; end
         S_MEMREAD:  begin req_c = 1'b1; adr_c = 1'b1; end
         S_MEMWB:    begin rw_c = 1'b1; res_c = RES_DATA; end
         S_MEMWRITE: begin req_c = 1'b1; adr_c = 1'b1; mw_c = bus.mem_ready; end
         S_EXEC_R:   begin srca_c = SRCA_RS1; srcb_c = SRCB_RS2; aluop_c = ALU_FUNCT; end
         S_EXEC_I:   begin srca_c = SRCA_RS1; srcb_c = SRCB_IMM; aluop_c = ALU_FUNCT; end
         S_LUI:      begin srca_c = SRCA_ZERO;  srcb_c = SRCB_IMM; end
         S_AUIPC:    begin srca_c = SRCA_OLDPC; srcb_c = SRCB_IMM; end
         S_JAL:      begin pcu_c = 1'b1; srca_c = SRCA_OLDPC; srcb_c = SRCB_FOUR; end
         S_ALUWB:    begin rw_c = 1'b1; end
         S_BRANCH:   begin br_c = 1'b1; srca_c = SRCA_RS1; aluop_c = ALU_SUB; end
         default: ;
      endcase
   end

   assign bus.mem_req    = req_c && reset_n;
   assign bus.PCUpdate   = pcu_c && reset_n;
   assign bus.Branch     = br_c  && reset_n;
   assign bus.MemWrite   = mw_c  && reset_n;
   assign bus.IRWrite    = irw_c && reset_n;
   assign bus.RegWrite   = rw_c  && reset_n;
   assign bus.AddrSrc    = adr_c;
   assign bus.ResultSrc  = res_c;
   assign bus.ALUOp      = aluop_c;
   assign bus.ALUSrcA    = srca_c;
   assign bus.ALUSrcB    = srcb_c;
   assign bus.ImmSrc     = imm_src(bus.op);
   assign bus.halted     = (state == S_TRAP);
   assign bus.trap_cause = cause_q;

`ifdef MC_CTRL_PERF_EN
   logic [CNT_W-1:0] cycle_q, instret_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         if (state != S_TRAP)
            cycle_q <= cycle_q + CNT_W'(1);
         if (state_nxt == S_FETCH && state != S_FETCH)
            instret_q <= instret_q + CNT_W'(1);
      end
   end

   assign bus.cycle_cnt   = cycle_q;
   assign bus.instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: per-cycle control vectors, stalls, timeout, traps, reset, perf counters.
module tb_mc_ctrl_fsm;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   mc_ctrl_fsm_if b ();
   mc_ctrl_fsm_if bs ();

   assign bs.op        = b.op;
   assign bs.funct3    = b.funct3;
   assign bs.mem_ready = b.mem_ready;

   mc_ctrl_fsm dut (.clk(clk), .reset_n(reset_n), .bus(b));
   mc_ctrl_fsm #(.TRAP_ON_ILLEGAL(0)) dut_skip (.clk(clk), .reset_n(reset_n), .bus(bs));

   // {halted, mem_req, PCUpdate, Branch, AddrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUOp, A, B}
   logic [15:0] obs, obs_s;
   logic [5:0]  strobes;
   assign obs = {b.halted, b.mem_req, b.PCUpdate, b.Branch, b.AddrSrc, b.MemWrite, b.IRWrite,
                 b.RegWrite, b.ResultSrc, b.ALUOp, b.ALUSrcA, b.ALUSrcB};
   assign obs_s = {bs.halted, bs.mem_req, bs.PCUpdate, bs.Branch, bs.AddrSrc, bs.MemWrite, bs.IRWrite,
                   bs.RegWrite, bs.ResultSrc, bs.ALUOp, bs.ALUSrcA, bs.ALUSrcB};
   assign strobes = {b.mem_req, b.PCUpdate, b.Branch, b.MemWrite, b.IRWrite, b.RegWrite};

   localparam int FE = 0, DE = 1, MA = 2, MR = 3, MB = 4, MW = 5, ER = 6, EI = 7;
   localparam int AW = 8, JL = 9, BR = 10, LU = 11, AU = 12, TR = 13;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] exp_ctl(input int s, input logic rdy);
      logic h, mr, pc, br, as, mw, ir, rw;
      logic [1:0] rs, ao, a, bb;
      h = 0; mr = 0; pc = 0; br = 0; as = 0; mw = 0; ir = 0; rw = 0;
      rs = 2'b00; ao = 2'b00; a = 2'b00; bb = 2'b00;
      case (s)
         FE: begin mr = 1; pc = rdy; ir = rdy; rs = 2'b10; bb = 2'b10; end
         DE: begin a = 2'b01; bb = 2'b01; end
         MA: begin a = 2'b10; bb = 2'b01; end
         MR: begin mr = 1; as = 1; end
         MB: begin rw = 1; rs = 2'b01; end
         MW: begin mr = 1; as = 1; mw = rdy; end
         ER: begin a = 2'b10; bb = 2'b00; ao = 2'b10; end
         EI: begin a = 2'b10; bb = 2'b01; ao = 2'b10; end
         AW: begin rw = 1; end
         JL: begin pc = 1; a = 2'b01; bb = 2'b10; end
         BR: begin br = 1; a = 2'b10; ao = 2'b01; end
         LU: begin a = 2'b11; bb = 2'b01; end
         AU: begin a = 2'b01; bb = 2'b01; end
         TR: begin h = 1; end
         default: ;
      endcase
      return {h, mr, pc, br, as, mw, ir, rw, rs, ao, a, bb};
   endfunction

   // Called at posedge+1: drive mem_ready, check at negedge, return at next posedge+1.
   task automatic step(input string tag, input int s, input logic rdy, input int s2 = -1);
      b.mem_ready = rdy;
      @(negedge clk);
      chk(tag, {16'h0, obs}, {16'h0, exp_ctl(s, rdy)});
      if (s2 >= 0)
         chk({tag, ".skip"}, {16'h0, obs_s}, {16'h0, exp_ctl(s2, rdy)});
      @(posedge clk);
      #1;
   endtask

   task automatic run(input string nm, input logic [6:0] o, input logic [2:0] imm, input int n,
                      input int s0, input int s1, input int s2, input int s3 = 0, input int s4 = 0);
      b.op = o;
      #1;
      chk({nm, ".imm"}, {29'h0, b.ImmSrc}, {29'h0, imm});
      for (int i = 0; i < n; i++) begin
         int s;
         case (i)
            0: s = s0;
            1: s = s1;
            2: s = s2;
            3: s = s3;
            default: s = s4;
         endcase
         step($sformatf("%s.%0d", nm, i), s, 1'b1);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      b.mem_ready = 1'b1;
      @(negedge clk);
      chk("rst.strobes", {26'h0, strobes}, 32'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      #1;
      chk("rst.halted", {31'h0, b.halted}, 32'h0);
      chk("rst.cause", {30'h0, b.trap_cause}, 32'h0);
   endtask

   initial begin
      b.op = 7'b0110011;
      b.funct3 = 3'b000;
      b.mem_ready = 1'b1;
      @(posedge clk);
      #1;
      do_reset();

      // zero-wait instruction mix
      run("ADD",   7'b0110011, 3'b000, 4, FE, DE, ER, AW);
      run("ADDI",  7'b0010011, 3'b000, 4, FE, DE, EI, AW);
      run("LW",    7'b0000011, 3'b000, 5, FE, DE, MA, MR, MB);
      run("SW",    7'b0100011, 3'b001, 4, FE, DE, MA, MW);
      run("BEQ",   7'b1100011, 3'b010, 3, FE, DE, BR);
      run("JAL",   7'b1101111, 3'b011, 4, FE, DE, JL, AW);
      run("JALR",  7'b1100111, 3'b000, 5, FE, DE, MA, JL, AW);
      run("LUI",   7'b0110111, 3'b100, 4, FE, DE, LU, AW);
      run("AUIPC", 7'b0010111, 3'b100, 4, FE, DE, AU, AW);

      // FETCH held 3 cycles, completes in the 4th
      b.op = 7'b0110011;
      for (int i = 0; i < 3; i++) step($sformatf("fstall.%0d", i), FE, 1'b0);
      step("fstall.go", FE, 1'b1);
      step("fstall.de", DE, 1'b1);
      step("fstall.ex", ER, 1'b1);
      step("fstall.wb", AW, 1'b1);

      // timeout: 15 stalled FETCH cycles then TRAP
      for (int i = 0; i < 15; i++) step($sformatf("tmo.%0d", i), FE, 1'b0);
      chk("tmo.cause", {30'h0, b.trap_cause}, 32'h2);
      step("tmo.trap0", TR, 1'b0);
      step("tmo.trap1", TR, 1'b1);
      step("tmo.trap2", TR, 1'b1);
      chk("tmo.cause_sticky", {30'h0, b.trap_cause}, 32'h2);

      // illegal opcode: trap in default build, skip in TRAP_ON_ILLEGAL=0 build
      do_reset();
      b.op = 7'b1111111;
      step("ill.fe", FE, 1'b1, FE);
      step("ill.de", DE, 1'b1, DE);
      chk("ill.cause", {30'h0, b.trap_cause}, 32'h1);
      step("ill.trap", TR, 1'b1, FE);

      // ADD, LW, SW back to back (perf counters), then ECALL
      do_reset();
      run("pADD", 7'b0110011, 3'b000, 4, FE, DE, ER, AW);
      run("pLW",  7'b0000011, 3'b000, 5, FE, DE, MA, MR, MB);
      run("pSW",  7'b0100011, 3'b001, 4, FE, DE, MA, MW);
`ifdef MC_CTRL_PERF_EN
      chk("perf.cycle", b.cycle_cnt, 32'd13);
      chk("perf.instret", b.instret_cnt, 32'd3);
`endif
      b.op = 7'b1110011;
      step("ecall.fe", FE, 1'b1);
      step("ecall.de", DE, 1'b1);
      chk("ecall.cause", {30'h0, b.trap_cause}, 32'h3);
      step("ecall.trap0", TR, 1'b1);
      step("ecall.trap1", TR, 1'b1);
`ifdef MC_CTRL_PERF_EN
      chk("perf.cycle_frozen", b.cycle_cnt, 32'd15);
      chk("perf.instret_frozen", b.instret_cnt, 32'd3);
`endif

      // reset during a stalled MEMWRITE: MemWrite must never pulse
      do_reset();
      b.op = 7'b0100011;
      step("swr.fe", FE, 1'b1);
      step("swr.de", DE, 1'b1);
      step("swr.ma", MA, 1'b1);
      step("swr.stall0", MW, 1'b0);
      step("swr.stall1", MW, 1'b0);
      reset_n = 1'b0;
      b.mem_ready = 1'b1;
      @(negedge clk);
      chk("swr.rst_memwrite", {31'h0, b.MemWrite}, 32'h0);
      chk("swr.rst_strobes", {26'h0, strobes}, 32'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      step("swr.refetch", FE, 1'b1);
      chk("swr.cause", {30'h0, b.trap_cause}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, limit 200000 expected earlier finish");
      $fatal(1);
   end

endmodule
